fir_reload_seq: RTL and testbench

Coefficient reload sequencer for the reloadable, symmetric FIR instances inside the receive ANC frequency-shift/LPF chains. It holds a software-writable coefficient RAM and, on command, streams the unique half-set of taps onto the FIR reload AXI-stream. It then issues the FIR config-commit beat and pulses `done`. A single sequencer drives the reload bus, which is fanned out to every filter sharing that coefficient set.

---
 rtl/fir_reload_seq.sv | 194 +++++++++++++++++++
 tb/tb_fir_reload_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_reload_seq.sv
// Coefficient reload sequencer: software-written coefficient RAM streamed onto the FIR reload bus, then a config commit.
// Optional FIR_RELOAD_AUTOSTART_EN: one automatic load after reset from an identity coefficient set.
module fir_reload_seq #(
  parameter int COEFF_WIDTH      = 16,
  parameter int NUM_COEFFS       = 128,
  parameter int SYMMETRIC_COEFFS = 1,
  parameter int ADDR_WIDTH       = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [COEFF_WIDTH-1:0] wr_data,
  output logic                   wr_drop,
  output logic [COEFF_WIDTH-1:0] reload_tdata,
  output logic                   reload_tvalid,
  input  logic                   reload_tready,
  output logic                   reload_tlast,
  output logic                   config_tvalid,
  input  logic                   config_tready,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  load_count
);

  localparam int NLOAD = (SYMMETRIC_COEFFS != 0) ? (NUM_COEFFS + 1) / 2 : NUM_COEFFS;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NLOAD - 1);
  localparam logic [ADDR_WIDTH-1:0] NLOAD_CNT = ADDR_WIDTH'(NLOAD);
  localparam logic [ADDR_WIDTH:0]   NLOAD_EXT = (ADDR_WIDTH + 1)'(NLOAD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    COMMIT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [COEFF_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   drop_q, drop_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]  count_q, count_d;
  logic [COEFF_WIDTH-1:0] ram_q [DEPTH];
  logic                   start_s;
  logic                   wr_ok_s;
  logic                   beat_hs_s;

`ifdef FIR_RELOAD_AUTOSTART_EN
  logic auto_q;

  // Internal start fires in the first cycle after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= 1'b0;
    end
  end

  assign start_s = start | auto_q;

  // Coefficient RAM, preloaded with a unity-gain identity set at reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_q[i] <= (i == NLOAD - 1) ? (COEFF_WIDTH'(1) << (COEFF_WIDTH - 2)) : '0;
      end
    end else if (wr_ok_s) begin
      ram_q[wr_addr] <= wr_data;
    end
  end
`else
  assign start_s = start;

  // Coefficient RAM; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      ram_q[wr_addr] <= wr_data;
    end
  end
`endif

  // Writes only land while idle and inside the stored half-set; a write issued with start still lands first.
  assign wr_ok_s   = wr_en & (state_q == IDLE) & ({1'b0, wr_addr} < NLOAD_EXT);
  assign beat_hs_s = tvalid_q & reload_tready;

  // Next-state and datapath; start takes priority everywhere and restarts the load.
  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    cfg_valid_d = cfg_valid_q;
    rd_addr_d   = rd_addr_q;
    count_d     = count_q;
    drop_d      = wr_en & ~wr_ok_s;
    if (start_s) begin
      state_d     = FETCH;
      tvalid_d    = 1'b0;
      tlast_d     = 1'b0;
      cfg_valid_d = 1'b0;
      rd_addr_d   = '0;
      count_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FETCH: begin
          tdata_d   = ram_q[rd_addr_q];
          tlast_d   = (rd_addr_q == LAST_IDX);
          tvalid_d  = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          state_d   = STREAM;
        end
        STREAM: begin
          if (beat_hs_s) begin
            if (count_q != NLOAD_CNT) begin
              count_d = count_q + ADDR_WIDTH'(1);
            end else begin
              count_d = count_q;
            end
            if (tlast_q) begin
              tvalid_d    = 1'b0;
              tlast_d     = 1'b0;
              cfg_valid_d = 1'b1;
              state_d     = COMMIT;
            end else begin
              // Next read issued in the handshake cycle keeps the stream bubble-free.
              tdata_d   = ram_q[rd_addr_q];
              tlast_d   = (rd_addr_q == LAST_IDX);
              rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end
          end else begin
            state_d = STREAM;
          end
        end
        COMMIT: begin
          if (config_tready) begin
            cfg_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = COMMIT;
          end
        end
        default: begin
          state_d     = IDLE;
          tvalid_d    = 1'b0;
          tlast_d     = 1'b0;
          cfg_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      rd_addr_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      cfg_valid_q <= cfg_valid_d;
      drop_q      <= drop_d;
      rd_addr_q   <= rd_addr_d;
      count_q     <= count_d;
    end
  end

  assign reload_tdata  = tdata_q;
  assign reload_tvalid = tvalid_q;
  assign reload_tlast  = tlast_q;
  assign config_tvalid = cfg_valid_q;
  assign wr_drop       = drop_q;
  assign busy          = (state_q != IDLE);
  assign load_count    = count_q;
  // An aborting start in the commit cycle suppresses completion.
  assign done          = cfg_valid_q & config_tready & ~start_s;

endmodule

// File: tb/tb_fir_reload_seq.sv
// Directed bench for fir_reload_seq: streaming, back-pressure, commit stall, abort, dropped writes, async reset.
module tb_fir_reload_seq;
  localparam int CW = 16;
  localparam int AW = 7;
  localparam int NL = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          wr_drop;
  logic [CW-1:0] reload_tdata;
  logic          reload_tvalid;
  logic          reload_tready;
  logic          reload_tlast;
  logic          config_tvalid;
  logic          config_tready;
  logic          busy;
  logic          done;
  logic [AW-1:0] load_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_before;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  fir_reload_seq #(
    .COEFF_WIDTH(CW), .NUM_COEFFS(128), .SYMMETRIC_COEFFS(1), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .reload_tdata(reload_tdata), .reload_tvalid(reload_tvalid),
    .reload_tready(reload_tready), .reload_tlast(reload_tlast),
    .config_tvalid(config_tvalid), .config_tready(config_tready),
    .busy(busy), .done(done), .load_count(load_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Consume one full load expecting data 1..NL; optional 1/0 ready toggling.
  task automatic stream_check(input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [CW-1:0] held = '0;
    while (idx < NL && cyc < 400) begin
      if (toggle) reload_tready = (cyc % 2 == 0);
      #1;
      if (stalled) begin
        chk("stall_valid", {31'd0, reload_tvalid}, 32'd1);
        chk("stall_data", {16'd0, reload_tdata}, {16'd0, held});
      end
      if (reload_tvalid === 1'b1) begin
        if (reload_tready) begin
          chk("beat_data", {16'd0, reload_tdata}, idx + 1);
          chk("beat_last", {31'd0, reload_tlast}, {31'd0, (idx == NL - 1)});
          idx++;
          stalled = 1'b0;
        end else begin
          held = reload_tdata;
          stalled = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
      tick();
      cyc++;
    end
    reload_tready = 1'b1;
    chk("stream_beats", idx, NL);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    reload_tready = 1'b1; config_tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", {31'd0, reload_tvalid}, 32'd0);
    chk("rst_tdata", {16'd0, reload_tdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg", {31'd0, config_tvalid}, 32'd0);
    chk("rst_count", {25'd0, load_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Load ramp 1..64.
    for (int i = 0; i < NL; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = CW'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    chk("wr_nodrop", {31'd0, wr_drop}, 32'd0);

    // Continuous ready: exact cycle timing from start.
    start = 1'b1; tick(); start = 1'b0;
    chk("c1_busy", {31'd0, busy}, 32'd1);
    chk("c1_tvalid", {31'd0, reload_tvalid}, 32'd0);
    chk("c1_count", {25'd0, load_count}, 32'd0);
    for (int k = 0; k < NL; k++) begin
      tick();
      chk("t1_valid", {31'd0, reload_tvalid}, 32'd1);
      chk("t1_data", {16'd0, reload_tdata}, k + 1);
      chk("t1_last", {31'd0, reload_tlast}, {31'd0, (k == NL - 1)});
      chk("t1_count", {25'd0, load_count}, k);
    end
    tick();
    chk("c66_cfg", {31'd0, config_tvalid}, 32'd1);
    chk("c66_done", {31'd0, done}, 32'd1);
    chk("c66_count", {25'd0, load_count}, NL);
    chk("c66_tvalid", {31'd0, reload_tvalid}, 32'd0);
    tick();
    chk("c67_busy", {31'd0, busy}, 32'd0);
    chk("c67_done", {31'd0, done}, 32'd0);
    chk("c67_cfg", {31'd0, config_tvalid}, 32'd0);

    // Toggling ready, then commit stalled 10 cycles.
    config_tready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    stream_check(1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("cstall_cfg", {31'd0, config_tvalid}, 32'd1);
      chk("cstall_done", {31'd0, done}, 32'd0);
      tick();
    end
    config_tready = 1'b1;
    #1;
    chk("cfg_hs_valid", {31'd0, config_tvalid}, 32'd1);
    chk("cfg_hs_done", {31'd0, done}, 32'd1);
    tick();
    chk("cfg_after", {31'd0, config_tvalid}, 32'd0);
    chk("cfg_busy", {31'd0, busy}, 32'd0);

    // Abort after 20 beats: restart from 1, exactly one done.
    done_before = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("ab_data", {16'd0, reload_tdata}, k + 1);
    end
    tick();
    chk("ab_count20", {25'd0, load_count}, 32'd20);
    start = 1'b1; tick(); start = 1'b0;
    chk("ab_fetch_valid", {31'd0, reload_tvalid}, 32'd0);
    chk("ab_count0", {25'd0, load_count}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd1);
    stream_check(1'b0);
    chk("ab_done", {31'd0, done}, 32'd1);
    tick();
    chk("ab_one_done", done_cnt - done_before, 32'd1);

    // Write while busy is dropped; RAM keeps 6 at address 5.
    start = 1'b1; tick(); start = 1'b0;
    wr_en = 1'b1; wr_addr = 7'd5; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    chk("drop_busy", {31'd0, wr_drop}, 32'd1);
    stream_check(1'b0);
    tick();
    chk("drop_clear", {31'd0, wr_drop}, 32'd0);
    wr_en = 1'b1; wr_addr = 7'd70; wr_data = 16'hDEAD;
    tick();
    wr_en = 1'b0;
    chk("drop_range", {31'd0, wr_drop}, 32'd1);
    tick();
    chk("drop_range_clr", {31'd0, wr_drop}, 32'd0);

    // Async reset at beat 30, then a full reload.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k <= 30; k++) tick();
    chk("pre_rst_data", {16'd0, reload_tdata}, 32'd31);
    reset_n = 1'b0;
    #1;
    chk("ar_tvalid", {31'd0, reload_tvalid}, 32'd0);
    chk("ar_tdata", {16'd0, reload_tdata}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_count", {25'd0, load_count}, 32'd0);
    chk("ar_cfg", {31'd0, config_tvalid}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    stream_check(1'b0);
    chk("ar_done", {31'd0, done}, 32'd1);
    tick();

    // Start together with a write: the load sees the new coefficient.
    wr_en = 1'b1; wr_addr = 7'd0; wr_data = 16'h0077; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("sw_nodrop", {31'd0, wr_drop}, 32'd0);
    tick();
    chk("sw_valid", {31'd0, reload_tvalid}, 32'd1);
    chk("sw_data", {16'd0, reload_tdata}, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
